// File: rtl/uart_tx.sv
// uart_tx: 8-bit async serial transmitter (start, LSB-first data, optional even parity, stop bits).
// Define UART_TX_PARITY_EN to insert an even-parity bit after D7.
module uart_tx #(
   parameter int CLKS_PER_BIT = 434,
   parameter int STOP_BITS    = 1
) (
   input  logic       clk,
   input  logic       rstn,
   input  logic       tx_start,
   input  logic [7:0] tx_byte,
   output logic       tx_ready,
   output logic       tx_accept,
   output logic       tx_done,
   output logic       txd
);
   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] PRE  = CW'(CLKS_PER_BIT - 2);
`ifdef UART_TX_PARITY_EN
   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
   logic par_q;
`else
   typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif
   state_t        state_q;
   logic [CW-1:0] cnt_q;
   logic [2:0]    idx_q;
   logic [7:0]    shift_q;
   logic          txd_q, ready_q, accept_q, done_q;
   logic          bit_end, stop_last;
   assign bit_end   = cnt_q == LAST;
   assign stop_last = idx_q == 3'(STOP_BITS - 1);
   assign txd       = txd_q;
   assign tx_ready  = ready_q;
   assign tx_accept = accept_q;
   assign tx_done   = done_q;
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         idx_q    <= '0;
         shift_q  <= '0;
         txd_q    <= 1'b1;
         ready_q  <= 1'b1;
         accept_q <= 1'b0;
         done_q   <= 1'b0;
`ifdef UART_TX_PARITY_EN
         par_q    <= 1'b0;
`endif
      end else begin
         accept_q <= 1'b0;
         done_q   <= 1'b0;
         cnt_q    <= bit_end ? '0 : cnt_q + CW'(1);
         case (state_q)
            IDLE: begin
               cnt_q <= '0;
               if (tx_start) begin
                  shift_q  <= tx_byte;
`ifdef UART_TX_PARITY_EN
                  par_q    <= ^tx_byte;
`endif
                  state_q  <= START;
                  txd_q    <= 1'b0;
                  ready_q  <= 1'b0;
                  accept_q <= 1'b1;
               end
            end
            START: if (bit_end) begin
               state_q <= DATA;
               idx_q   <= '0;
               txd_q   <= shift_q[0];
            end
            DATA: if (bit_end) begin
               shift_q <= shift_q >> 1;
               idx_q   <= idx_q + 3'd1;
               if (idx_q == 3'd7) begin
                  idx_q   <= '0;
`ifdef UART_TX_PARITY_EN
                  state_q <= PARITY;
                  txd_q   <= par_q;
`else
                  state_q <= STOP;
                  txd_q   <= 1'b1;
`endif
               end else begin
                  txd_q <= shift_q[1];
               end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: if (bit_end) begin
               state_q <= STOP;
               idx_q   <= '0;
               txd_q   <= 1'b1;
            end
`endif
            STOP: begin
               // done is registered one cycle early so it lands in the final stop-bit cycle
               if (stop_last && cnt_q == PRE) done_q <= 1'b1;
               if (bit_end) begin
                  if (stop_last) begin
                     state_q <= IDLE;
                     idx_q   <= '0;
                     ready_q <= 1'b1;
                  end else begin
                     idx_q <= idx_q + 3'd1;
                  end
               end
            end
            default: begin
               state_q <= IDLE;
               txd_q   <= 1'b1;
               ready_q <= 1'b1;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: directed self-checking bench for uart_tx at CLKS_PER_BIT=4, one stop bit.
module tb_uart_tx;
   localparam int C = 4;
`ifdef UART_TX_PARITY_EN
   localparam int P = 1;
`else
   localparam int P = 0;
`endif
   localparam int NB = 10 + P;
   localparam int F  = NB * C;

   logic       clk = 1'b0;
   logic       rstn = 1'b0;
   logic       tx_start = 1'b0;
   logic [7:0] tx_byte = 8'h00;
   logic       tx_ready, tx_accept, tx_done, txd;
   int         cyc = 0;
   int         n_cmp = 0;
   int         n_err = 0;

   uart_tx #(.CLKS_PER_BIT(C), .STOP_BITS(1)) dut (
      .clk(clk), .rstn(rstn), .tx_start(tx_start), .tx_byte(tx_byte),
      .tx_ready(tx_ready), .tx_accept(tx_accept), .tx_done(tx_done), .txd(txd)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [15:0] exp_frame(input logic [7:0] b);
      logic [15:0] f;
      f = '0;
      for (int j = 1; j <= 8; j++) f[j] = b[j-1];
      if (P == 1) f[9] = ^b;
      f[9+P] = 1'b1;
      return f;
   endfunction

   // Starts one frame from a negedge with tx_ready high and records what the line does.
   task automatic capture(input logic [7:0] b, input logic [7:0] nxt, input bit hold,
                          input int pulse_k, input logic [7:0] pulse_b,
                          output logic [15:0] bits, output int acc_n, output int done_n,
                          output int done_k, output int ready_k, output int acc_cyc,
                          output logic first_txd);
      bits = '0; acc_n = 0; done_n = 0; done_k = -1; ready_k = -1; acc_cyc = -1;
      first_txd = 1'bx;
      tx_start = 1'b1;
      tx_byte  = b;
      @(posedge clk);
      for (int k = 0; k <= F; k++) begin
         @(negedge clk);
         if (k == 0) first_txd = txd;
         if (tx_accept) begin
            acc_n++;
            if (acc_cyc < 0) acc_cyc = cyc;
         end
         if (tx_done) begin
            done_n++;
            done_k = k;
         end
         if (tx_ready && ready_k < 0) ready_k = k;
         if (k < NB * C && k % C == C / 2) bits[k/C] = txd;
         tx_start = hold || (k == pulse_k);
         tx_byte  = (k == pulse_k) ? pulse_b : nxt;
      end
   endtask

   logic [15:0] bits;
   int          acc_n, done_n, done_k, ready_k, acc_cyc;
   logic        first_txd;

   task automatic test_reset();
      #12;
      n_cmp++; if (txd !== 1'b1)       begin n_err++; $display("FAIL reset_txd: got %b want 1", txd); end
      n_cmp++; if (tx_ready !== 1'b1)  begin n_err++; $display("FAIL reset_ready: got %b want 1", tx_ready); end
      n_cmp++; if (tx_accept !== 1'b0) begin n_err++; $display("FAIL reset_accept: got %b want 0", tx_accept); end
      n_cmp++; if (tx_done !== 1'b0)   begin n_err++; $display("FAIL reset_done: got %b want 0", tx_done); end
      @(negedge clk);
      rstn = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_single();
      capture(8'h55, 8'hFF, 1'b0, -1, 8'h00, bits, acc_n, done_n, done_k, ready_k, acc_cyc, first_txd);
      n_cmp++; if (first_txd !== 1'b0) begin n_err++; $display("FAIL single_start: got %b want 0", first_txd); end
      n_cmp++; if (bits !== ((P == 1) ? 16'h04AA : 16'h02AA))
         begin n_err++; $display("FAIL single_bits: got %h want %h", bits, (P == 1) ? 16'h04AA : 16'h02AA); end
      n_cmp++; if (acc_n !== 1)     begin n_err++; $display("FAIL single_accepts: got %0d want 1", acc_n); end
      n_cmp++; if (done_n !== 1)    begin n_err++; $display("FAIL single_dones: got %0d want 1", done_n); end
      n_cmp++; if (done_k !== F-1)  begin n_err++; $display("FAIL single_done_at: got %0d want %0d", done_k, F-1); end
      n_cmp++; if (ready_k !== F)   begin n_err++; $display("FAIL single_ready_at: got %0d want %0d", ready_k, F); end
      n_cmp++; if (txd !== 1'b1)    begin n_err++; $display("FAIL single_idle_txd: got %b want 1", txd); end
   endtask

   task automatic test_parity();
      logic [7:0] v [2] = '{8'h07, 8'h03};
      logic       ph [2] = '{1'b1, 1'b0};
      for (int i = 0; i < 2; i++) begin
         capture(v[i], 8'h00, 1'b0, -1, 8'h00, bits, acc_n, done_n, done_k, ready_k, acc_cyc, first_txd);
         n_cmp++; if (bits !== exp_frame(v[i]))
            begin n_err++; $display("FAIL parity_bits[%0d]: got %h want %h", i, bits, exp_frame(v[i])); end
         n_cmp++; if (bits[9] !== ((P == 1) ? ph[i] : 1'b1))
            begin n_err++; $display("FAIL parity_slot[%0d]: got %b want %b", i, bits[9], (P == 1) ? ph[i] : 1'b1); end
         n_cmp++; if (ready_k !== F) begin n_err++; $display("FAIL parity_len[%0d]: got %0d want %0d", i, ready_k, F); end
      end
   endtask

   task automatic test_busy_ignore();
      int extra;
      capture(8'h41, 8'h00, 1'b0, 4, 8'hAA, bits, acc_n, done_n, done_k, ready_k, acc_cyc, first_txd);
      extra = 0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         if (tx_accept || !tx_ready) extra++;
      end
      n_cmp++; if (bits !== exp_frame(8'h41)) begin n_err++; $display("FAIL busy_bits: got %h want %h", bits, exp_frame(8'h41)); end
      n_cmp++; if (acc_n !== 1) begin n_err++; $display("FAIL busy_accepts: got %0d want 1", acc_n); end
      n_cmp++; if (extra !== 0) begin n_err++; $display("FAIL busy_late_accept: got %0d want 0", extra); end
   endtask

   task automatic test_back_to_back();
      logic [7:0] msg [5] = '{8'h4F, 8'h4B, 8'h0D, 8'h0A, 8'h00};
      int prev;
      prev = 0;
      for (int i = 0; i < 4; i++) begin
         capture(msg[i], msg[i+1], i < 3, -1, 8'h00, bits, acc_n, done_n, done_k, ready_k, acc_cyc, first_txd);
         n_cmp++; if (bits !== exp_frame(msg[i]))
            begin n_err++; $display("FAIL b2b_bits[%0d]: got %h want %h", i, bits, exp_frame(msg[i])); end
         if (i > 0) begin
            n_cmp++; if (acc_cyc - prev !== F + 1)
               begin n_err++; $display("FAIL b2b_period[%0d]: got %0d want %0d", i, acc_cyc - prev, F + 1); end
         end
         prev = acc_cyc;
      end
   endtask

   task automatic test_reset_mid();
      logic pre;
      tx_start = 1'b1;
      tx_byte  = 8'h00;
      @(posedge clk);
      pre = 1'bx;
      for (int k = 0; k <= 17; k++) begin
         @(negedge clk);
         tx_start = 1'b0;
         pre = txd;
      end
      rstn = 1'b0;
      #1;
      n_cmp++; if (pre !== 1'b0)       begin n_err++; $display("FAIL mid_pre_txd: got %b want 0", pre); end
      n_cmp++; if (txd !== 1'b1)       begin n_err++; $display("FAIL mid_txd: got %b want 1", txd); end
      n_cmp++; if (tx_ready !== 1'b1)  begin n_err++; $display("FAIL mid_ready: got %b want 1", tx_ready); end
      n_cmp++; if (tx_accept !== 1'b0 || tx_done !== 1'b0)
         begin n_err++; $display("FAIL mid_pulses: got %b%b want 00", tx_accept, tx_done); end
      @(negedge clk);
      rstn = 1'b1;
      @(negedge clk);
      capture(8'h5A, 8'h00, 1'b0, -1, 8'h00, bits, acc_n, done_n, done_k, ready_k, acc_cyc, first_txd);
      n_cmp++; if (bits !== exp_frame(8'h5A)) begin n_err++; $display("FAIL mid_after_bits: got %h want %h", bits, exp_frame(8'h5A)); end
      n_cmp++; if (ready_k !== F) begin n_err++; $display("FAIL mid_after_len: got %0d want %0d", ready_k, F); end
   endtask

   initial begin
      test_reset();
      test_single();
      test_parity();
      test_busy_ignore();
      test_back_to_back();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
